vecmat32_seq: RTL and testbench

Sequencer for the 32-lane vector-matrix dot-product datapath in the attention block: 32 multipliers, a two-stage adder tree and a 16-bit result register. The block latches one 512-bit softmax vector at `start`, then streams N matrix columns in over a valid/ready port and drives each one into the datapath. It tracks every column through the fixed pipeline latency and returns the 16-bit dot products, tagged with the column index, through a credit-protected output FIFO. It sits between the V-matrix column fetch and the attention output writer.

---
 rtl/vecmat32_seq.sv | 169 ++++++++++++++++
 tb/tb_vecmat32_seq.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vecmat32_seq.sv
// vecmat32_seq: column sequencer for the 32-lane vector-matrix dot-product datapath.
// Optional performance counters are built when VECMAT_SEQ_PERF_EN is defined.
module vecmat32_seq #(
  parameter int PIPE_LAT   = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] num_cols,
  input  logic [511:0]     vec_in,
  input  logic             col_valid,
  output logic             col_ready,
  input  logic [511:0]     col_data,
  output logic [511:0]     dp_vector,
  output logic [511:0]     dp_matrix,
  input  logic [15:0]      dp_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic [IDX_W-1:0] res_idx,
  output logic             busy,
  output logic             done,
  output logic [31:0]      perf_busy,
  output logic [31:0]      perf_stall
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int INF_W = $clog2(PIPE_LAT + 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_num_cols;
  logic [IDX_W-1:0]   r_issued;
  logic [IDX_W-1:0]   r_popped;
  logic [PIPE_LAT:0]  r_vpipe;
  logic [IDX_W-1:0]   r_tag [0:PIPE_LAT];
  logic [15:0]        r_fifo_data [0:FIFO_DEPTH-1];
  logic [IDX_W-1:0]   r_fifo_idx [0:FIFO_DEPTH-1];
  logic [PTR_W:0]     r_wptr;
  logic [PTR_W:0]     r_rptr;
  logic [511:0]       r_dp_vector;
  logic [511:0]       r_dp_matrix;
  logic               r_done;

  logic [PTR_W:0]     w_fifo_count;
  logic [INF_W-1:0]   w_inflight;
  logic               w_credit;
  logic               w_col_hs;
  logic               w_capture;
  logic               w_res_valid;
  logic               w_pop;
  logic [IDX_W-1:0]   w_issued_nxt;
  logic [IDX_W-1:0]   w_popped_nxt;

  // Columns still in the datapath hold a FIFO slot in reserve until captured.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i <= PIPE_LAT; i++) w_inflight = w_inflight + INF_W'(r_vpipe[i]);
  end

  assign w_fifo_count = r_wptr - r_rptr;
  assign w_credit     = (int'(w_inflight) + int'(w_fifo_count)) < FIFO_DEPTH;
  assign col_ready    = (r_state == S_RUN) && (r_issued < r_num_cols) && w_credit;
  assign w_col_hs     = col_valid && col_ready;
  assign w_capture    = r_vpipe[PIPE_LAT];
  assign w_res_valid  = (w_fifo_count != '0);
  assign w_pop        = w_res_valid && res_ready;
  assign w_issued_nxt = r_issued + 1'b1;
  assign w_popped_nxt = r_popped + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_num_cols  <= '0;
      r_issued    <= '0;
      r_popped    <= '0;
      r_vpipe     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_dp_vector <= '0;
      r_dp_matrix <= '0;
      r_done      <= 1'b0;
    end else begin
      r_vpipe <= {r_vpipe[PIPE_LAT-1:0], w_col_hs};
      r_done  <= 1'b0;
      if (w_capture) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr   <= r_rptr + 1'b1;
        r_popped <= w_popped_nxt;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_cols  <= num_cols;
            r_dp_vector <= vec_in;
            r_issued    <= '0;
            r_popped    <= '0;
            r_vpipe     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_state     <= (num_cols == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_col_hs) begin
            r_dp_matrix <= col_data;
            r_issued    <= w_issued_nxt;
            if (w_issued_nxt == r_num_cols) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && (w_popped_nxt == r_num_cols)) r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag and result storage carry data only; validity lives in r_vpipe and the pointers.
  always_ff @(posedge clk) begin
    r_tag[0] <= r_issued;
    for (int i = 1; i <= PIPE_LAT; i++) r_tag[i] <= r_tag[i-1];
    if (w_capture) begin
      r_fifo_data[r_wptr[PTR_W-1:0]] <= dp_result;
      r_fifo_idx[r_wptr[PTR_W-1:0]]  <= r_tag[PIPE_LAT];
    end
  end

  assign res_valid = w_res_valid;
  assign res_data  = w_res_valid ? r_fifo_data[r_rptr[PTR_W-1:0]] : '0;
  assign res_idx   = w_res_valid ? r_fifo_idx[r_rptr[PTR_W-1:0]]  : '0;
  assign dp_vector = r_dp_vector;
  assign dp_matrix = r_dp_matrix;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

`ifdef VECMAT_SEQ_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_stall;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_busy  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (busy) r_perf_busy <= sat_inc(r_perf_busy);
      if ((r_state == S_RUN) && col_valid && !col_ready) r_perf_stall <= sat_inc(r_perf_stall);
    end
  end

  assign perf_busy  = r_perf_busy;
  assign perf_stall = r_perf_stall;
`else
  assign perf_busy  = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_vecmat32_seq.sv
// Self-checking bench for vecmat32_seq with a behavioural 3-cycle datapath and a dot-product reference.
module tb_vecmat32_seq;
  localparam int IDX_W = 8;
  localparam int FIFO_DEPTH = 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic [IDX_W-1:0] num_cols;
  logic [511:0]     vec_in;
  logic             col_valid;
  logic             col_ready;
  logic [511:0]     col_data;
  logic [511:0]     dp_vector;
  logic [511:0]     dp_matrix;
  logic [15:0]      dp_result;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_data;
  logic [IDX_W-1:0] res_idx;
  logic             busy;
  logic             done;
  logic [31:0]      perf_busy;
  logic [31:0]      perf_stall;

  int n_tests = 0;
  int n_fail  = 0;

  vecmat32_seq #(.PIPE_LAT(3), .FIFO_DEPTH(FIFO_DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .start(start), .num_cols(num_cols), .vec_in(vec_in),
    .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data),
    .dp_vector(dp_vector), .dp_matrix(dp_matrix), .dp_result(dp_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
    .busy(busy), .done(done), .perf_busy(perf_busy), .perf_stall(perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] dot(input logic [511:0] v, input logic [511:0] c);
    logic [31:0] s;
    s = '0;
    for (int l = 0; l < 32; l++) s = s + 32'(v[16*l +: 16]) * 32'(c[16*l +: 16]);
    return s[15:0];
  endfunction

  // External datapath: multiplier register, adder-tree flop, output register.
  logic [15:0] d1, d2;
  always @(posedge clk) begin
    d1        <= dot(dp_vector, dp_matrix);
    d2        <= d1;
    dp_result <= d2;
  end

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int w = 0; w < 16; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_job(input int n, input logic [511:0] v);
    start = 1'b1; num_cols = IDX_W'(n); vec_in = v;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_tests++;
    if (col_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl got cr=%b rv=%b busy=%b done=%b need all 0", col_ready, res_valid, busy, done);
    end
    n_tests++;
    if (dp_vector !== '0 || dp_matrix !== '0 || res_data !== '0 || res_idx !== '0 || perf_busy !== '0 || perf_stall !== '0) begin
      n_fail++; $display("FAIL reset_data got rd=%0d ri=%0d pb=%0d ps=%0d need 0 and zero operands", res_data, res_idx, perf_busy, perf_stall);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [511:0] v, c;
    int acc, pop, cyc, first_acc, first_rv;
    for (int l = 0; l < 32; l++) begin v[16*l +: 16] = 16'd1; c[16*l +: 16] = 16'd2; end
    start_job(4, v);
    acc = 0; pop = 0; cyc = 0; first_acc = -1; first_rv = -1;
    res_ready = 1'b1;
    while (pop < 4 && cyc < 200) begin
      col_valid = (acc < 4); col_data = c;
      if (res_valid && first_rv < 0) first_rv = cyc;
      if (col_valid && col_ready) begin
        if (first_acc < 0) first_acc = cyc;
        acc++;
      end
      if (res_valid && res_ready) begin
        n_tests++;
        if (res_data !== 16'd64 || res_idx !== IDX_W'(pop)) begin
          n_fail++; $display("FAIL basic_result got data=%0d idx=%0d need data=64 idx=%0d", res_data, res_idx, pop);
        end
        pop++;
      end
      tick(); cyc++;
    end
    col_valid = 1'b0;
    n_tests++;
    if (pop != 4) begin n_fail++; $display("FAIL basic_count got %0d results need 4", pop); end
    n_tests++;
    if (first_rv != first_acc + 5) begin
      n_fail++; $display("FAIL basic_latency got first res_valid at %0d need %0d", first_rv, first_acc + 5);
    end
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_early got %b need 0", done); end
    tick();
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done got done=%b busy=%b need 1/0", done, busy); end
    tick();
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b need 0", done); end
    res_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int job = 0; job < 4; job++) begin
      logic [511:0] v;
      logic [511:0] cols [$];
      int n, acc, pop, cyc, max_out, extra_ready, done_seen;
      n = $urandom_range(1, 12);
      v = rand512();
      cols.delete();
      for (int k = 0; k < n; k++) cols.push_back(rand512());
      start_job(n, v);
      acc = 0; pop = 0; cyc = 0; max_out = 0; extra_ready = 0; done_seen = 0;
      while (pop < n && cyc < 2000) begin
        col_valid = (acc < n) && ($urandom_range(0, 3) != 0);
        col_data  = (acc < n) ? cols[acc] : '0;
        res_ready = ($urandom_range(0, 2) != 0);
        if (col_ready && acc >= n) extra_ready++;
        if (col_valid && col_ready) acc++;
        if (res_valid && res_ready) begin
          n_tests++;
          if (res_data !== dot(v, cols[pop]) || res_idx !== IDX_W'(pop)) begin
            n_fail++; $display("FAIL random_result job=%0d got data=%0d idx=%0d need data=%0d idx=%0d",
                               job, res_data, res_idx, dot(v, cols[pop]), pop);
          end
          pop++;
        end
        if (acc - pop > max_out) max_out = acc - pop;
        tick(); cyc++;
      end
      col_valid = 1'b0; res_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (done) done_seen++;
        tick();
      end
      n_tests++;
      if (pop != n || extra_ready != 0 || max_out > FIFO_DEPTH) begin
        n_fail++; $display("FAIL random_flow job=%0d got pops=%0d extra_ready=%0d max_out=%0d need pops=%0d 0 <=%0d",
                           job, pop, extra_ready, max_out, n, FIFO_DEPTH);
      end
      n_tests++;
      if (done_seen != 1) begin n_fail++; $display("FAIL random_done job=%0d got %0d pulses need 1", job, done_seen); end
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] v;
    logic [511:0] cols [8];
    int acc, pop, cyc;
    logic [31:0] s0, b0;
    v = rand512();
    for (int k = 0; k < 8; k++) cols[k] = rand512();
    start_job(8, v);
    acc = 0; pop = 0;
    res_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      col_valid = (acc < 8); col_data = cols[acc < 8 ? acc : 7];
      if (col_valid && col_ready) acc++;
      tick();
    end
    n_tests++;
    if (acc != 4 || col_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_credit got accepted=%0d col_ready=%b need 4/0", acc, col_ready);
    end
    col_valid = 1'b0;
    tick();
    s0 = perf_stall; b0 = perf_busy;
    col_valid = 1'b1; col_data = cols[4];
    for (int i = 0; i < 5; i++) begin
      if (col_ready) acc++;
      tick();
    end
    col_valid = 1'b0;
`ifdef VECMAT_SEQ_PERF_EN
    n_tests++;
    if (perf_stall - s0 !== 32'd5 || acc != 4) begin
      n_fail++; $display("FAIL perf_stall got delta=%0d accepted=%0d need 5/4", perf_stall - s0, acc);
    end
    n_tests++;
    if (perf_busy - b0 !== 32'd5) begin n_fail++; $display("FAIL perf_busy got delta=%0d need 5", perf_busy - b0); end
`else
    n_tests++;
    if (perf_stall !== 32'd0 || perf_busy !== 32'd0 || acc != 4) begin
      n_fail++; $display("FAIL perf_off got stall=%0d busy=%0d accepted=%0d need 0/0/4", perf_stall, perf_busy, acc);
    end
    n_tests++;
    if (s0 !== 32'd0 || b0 !== 32'd0) begin n_fail++; $display("FAIL perf_off_snap got %0d/%0d need 0/0", s0, b0); end
`endif
    res_ready = 1'b1; cyc = 0;
    while (pop < 8 && cyc < 500) begin
      col_valid = (acc < 8); col_data = cols[acc < 8 ? acc : 7];
      if (col_valid && col_ready) acc++;
      if (res_valid) begin
        n_tests++;
        if (res_data !== dot(v, cols[pop]) || res_idx !== IDX_W'(pop)) begin
          n_fail++; $display("FAIL bp_result got data=%0d idx=%0d need data=%0d idx=%0d", res_data, res_idx, dot(v, cols[pop]), pop);
        end
        pop++;
      end
      tick(); cyc++;
    end
    col_valid = 1'b0; res_ready = 1'b0;
    n_tests++;
    if (pop != 8) begin n_fail++; $display("FAIL bp_count got %0d results need 8", pop); end
    tick(); tick();
  endtask

  task automatic test_zero();
    int done_at, done_cnt, bad;
    logic [31:0] b0;
    b0 = perf_busy;
    start = 1'b1; num_cols = '0; vec_in = rand512();
    done_at = -1; done_cnt = 0; bad = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      start = 1'b0;
      if (col_ready || res_valid) bad++;
      if (done) begin done_cnt++; done_at = i; end
    end
    n_tests++;
    if (done_cnt != 1 || done_at != 2) begin
      n_fail++; $display("FAIL zero_done got %0d pulses at cycle %0d need 1 at cycle 2", done_cnt, done_at);
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL zero_quiet got %0d active cycles need 0", bad); end
`ifdef VECMAT_SEQ_PERF_EN
    n_tests++;
    if (perf_busy - b0 !== 32'd1) begin n_fail++; $display("FAIL zero_perf_busy got delta=%0d need 1", perf_busy - b0); end
`endif
  endtask

  task automatic test_reset_midjob();
    logic [511:0] v;
    logic [511:0] c [2];
    int acc, pop, cyc, leak;
    start_job(8, rand512());
    acc = 0; cyc = 0; res_ready = 1'b0;
    while (acc < 3 && cyc < 50) begin
      col_valid = 1'b1; col_data = rand512();
      if (col_ready) acc++;
      tick(); cyc++;
    end
    col_valid = 1'b0;
    reset = 1'b1;
    tick();
    n_tests++;
    if (col_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        dp_vector !== '0 || dp_matrix !== '0 || res_data !== '0 || res_idx !== '0 ||
        perf_busy !== '0 || perf_stall !== '0) begin
      n_fail++; $display("FAIL midreset_outputs got cr=%b rv=%b busy=%b done=%b rd=%0d ri=%0d need all 0",
                         col_ready, res_valid, busy, done, res_data, res_idx);
    end
    reset = 1'b0;
    leak = 0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid || done || busy) leak++;
      tick();
    end
    n_tests++;
    if (leak != 0) begin n_fail++; $display("FAIL midreset_discard got %0d active cycles need 0", leak); end
    v = rand512(); c[0] = rand512(); c[1] = rand512();
    start_job(2, v);
    acc = 0; pop = 0; cyc = 0; res_ready = 1'b1;
    while (pop < 2 && cyc < 100) begin
      col_valid = (acc < 2); col_data = c[acc < 2 ? acc : 1];
      if (col_valid && col_ready) acc++;
      if (res_valid) begin
        n_tests++;
        if (res_data !== dot(v, c[pop]) || res_idx !== IDX_W'(pop)) begin
          n_fail++; $display("FAIL midreset_next got data=%0d idx=%0d need data=%0d idx=%0d", res_data, res_idx, dot(v, c[pop]), pop);
        end
        pop++;
      end
      tick(); cyc++;
    end
    col_valid = 1'b0; res_ready = 1'b0;
    n_tests++;
    if (pop != 2) begin n_fail++; $display("FAIL midreset_count got %0d results need 2", pop); end
    tick(); tick();
  endtask

  task automatic test_start_ignored();
    logic [511:0] v1;
    logic [511:0] c [3];
    int acc, pop, cyc, extra, done_seen;
    v1 = rand512();
    for (int k = 0; k < 3; k++) c[k] = rand512();
    start_job(3, v1);
    acc = 0; pop = 0; cyc = 0; extra = 0; done_seen = 0;
    res_ready = 1'b1;
    while (acc < 1 && cyc < 20) begin
      col_valid = 1'b1; col_data = c[0];
      if (col_ready) acc++;
      if (res_valid) pop++;
      tick(); cyc++;
    end
    col_valid = 1'b0;
    start = 1'b1; num_cols = 8'd7; vec_in = rand512();
    tick();
    start = 1'b0;
    n_tests++;
    if (dp_vector !== v1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL restart_vector got busy=%b vector_changed=%b need busy=1 unchanged", busy, dp_vector !== v1);
    end
    cyc = 0;
    while (cyc < 40) begin
      col_valid = (acc < 3); col_data = c[acc < 3 ? acc : 2];
      if (col_ready && acc >= 3) extra++;
      if (col_valid && col_ready) acc++;
      if (done) done_seen++;
      if (res_valid) begin
        n_tests++;
        if (pop >= 3 || res_data !== dot(v1, c[pop < 3 ? pop : 2]) || res_idx !== IDX_W'(pop)) begin
          n_fail++; $display("FAIL restart_result got data=%0d idx=%0d at result %0d", res_data, res_idx, pop);
        end
        pop++;
      end
      tick(); cyc++;
    end
    col_valid = 1'b0; res_ready = 1'b0;
    n_tests++;
    if (pop != 3 || acc != 3 || extra != 0 || done_seen != 1) begin
      n_fail++; $display("FAIL restart_count got results=%0d accepted=%0d extra=%0d done=%0d need 3/3/0/1",
                         pop, acc, extra, done_seen);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_cols = '0; vec_in = '0;
    col_valid = 1'b0; col_data = '0; res_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_random();
    test_backpressure();
    test_zero();
    test_reset_midjob();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
